// File: rtl/blink_rate_pkg.sv
// Shared constants and types for the blink rate meter.
// Latency: none (declarations only).
// Backpressure: none.
package blink_rate_pkg;

    localparam int NUM_RATES = 9;

    // Code reported when a measurement falls outside every tolerance window.
    localparam logic [3:0] RATE_UNKNOWN = 4'd0;

    // Nominal half-periods in eighths of a second; index 0 is rate code 1.
    localparam logic [NUM_RATES-1:0][5:0] RATE_EIGHTHS = {
        6'd32, 6'd24, 6'd16, 6'd12, 6'd8, 6'd6, 6'd4, 6'd2, 6'd1
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } meter_state_t;

    // Rate code for table index idx.
    function automatic logic [3:0] code_of_index(input int idx);
        return 4'(idx + 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Brings an asynchronous line into the clock domain and flags every transition.
// Latency: edge_pulse is high in the cycle after the second sampling edge.
// Backpressure: none; one pulse per transition, no holding.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_pulse
);

    logic meta;
    logic stable;
    logic prev;

    // Two-flop synchronizer plus a delayed copy for edge detection.
    // A line held high through reset reads as one transition after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            stable <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= async_in;
            stable <= meta;
            prev   <= stable;
        end
    end

    // Rising and falling transitions both count.
    assign edge_pulse = stable ^ prev;

endmodule

// File: rtl/blink_rate_meter.sv
// Measures the interval between transitions of a blinking line, classifies it, reports lock.
// Latency: results appear 3 clock edges after the first sampling edge of a transition.
// Backpressure: none; meas_valid and timeout are single-cycle pulses, data holds until replaced.
module blink_rate_meter
    import blink_rate_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int CNT_W           = 28,
    parameter int TOL_SHIFT       = 4,
    parameter int TIMEOUT_EIGHTHS = 40
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             blink_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] half_period,
    output logic [3:0]       rate_code,
    output logic             locked,
    output logic             timeout
);

    localparam longint UNIT = longint'(CLK_HZ / 8);
    localparam logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(longint'(TIMEOUT_EIGHTHS) * UNIT);

    logic             blink_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] meas;
    logic [NUM_RATES-1:0] hit;
    logic [3:0]       code;
    meter_state_t     state;

    sync_edge u_sync_edge (
        .clk        (CLOCK_50),
        .rst        (RESET),
        .async_in   (blink_in),
        .edge_pulse (blink_edge)
    );

    // cnt counts cycles since the previous edge minus one, so the interval
    // that an edge arriving this cycle would close is cnt + 1 (saturating).
    assign meas = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // Tolerance windows fixed at elaboration: nominal +/- nominal >> TOL_SHIFT.
    for (genvar g = 0; g < NUM_RATES; g++) begin : g_window
        localparam longint NOM = UNIT * longint'(RATE_EIGHTHS[g]);
        localparam longint TOL = NOM >> TOL_SHIFT;
        localparam logic [CNT_W-1:0] LO = CNT_W'(NOM - TOL);
        localparam logic [CNT_W-1:0] HI = CNT_W'(NOM + TOL);
        assign hit[g] = (meas >= LO) && (meas <= HI);
    end

    // Map the matching window to its code; windows are disjoint so at most one hits.
    always_comb begin
        code = RATE_UNKNOWN;
        for (int i = 0; i < NUM_RATES; i++) begin
            if (hit[i]) begin
                code = code_of_index(i);
            end
        end
    end

    // Measurement FSM with registered outputs; rate_code doubles as the
    // previous code for the lock comparison, so clearing it clears history.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            meas_valid  <= 1'b0;
            half_period <= '0;
            rate_code   <= RATE_UNKNOWN;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (blink_edge) begin
                        state <= ARMED;
                    end
                end
                ARMED, LOCKED: begin
                    if (blink_edge) begin
                        // An edge wins over a simultaneous timeout threshold.
                        cnt         <= '0;
                        meas_valid  <= 1'b1;
                        half_period <= meas;
                        rate_code   <= code;
                        if ((code != RATE_UNKNOWN) && (code == rate_code)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state  <= ARMED;
                            locked <= 1'b0;
                        end
                    end else if (meas == TIMEOUT_CYC) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        timeout     <= 1'b1;
                        half_period <= '0;
                        rate_code   <= RATE_UNKNOWN;
                        locked      <= 1'b0;
                    end else begin
                        cnt <= meas;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/blink_rate_meter.md
Name: blink_rate_meter

Overview:
- Receive-side counterpart of the switch-selected LED blinker: samples one asynchronous blinking line and measures the interval between consecutive transitions.
- Classifies each interval into one of the nine board blink rates and reports lock once the rate is stable.
- Sits between a GPIO pin (or looped-back LED line) and the 7-segment/LED status logic on the 50 MHz board design.

Parameters:
CLK_HZ, 50000000, clock frequency; all nominal half-periods derive from it in units of CLK_HZ/8.
CNT_W, 28, interval counter width; must hold 5*CLK_HZ.
TOL_SHIFT, 4, match tolerance = nominal >> TOL_SHIFT (6.25 %).
TIMEOUT_EIGHTHS, 40, no-edge timeout in eighths of a second (40 = 5 s).

Ports:
CLOCK_50  in  1  system clock.
RESET  in  1  asynchronous, active-high reset.
blink_in  in  1  asynchronous blinking input.
meas_valid  out  1  one-cycle pulse: new measurement on half_period and rate_code.
half_period  out  CNT_W  last measured interval between transitions, in clocks.
rate_code  out  4  class of last measurement: 0 unknown, 1..9 = 0.125/0.25/0.5/0.75/1/1.5/2/3/4 s.
locked  out  1  two consecutive measurements gave the same nonzero code.
timeout  out  1  one-cycle pulse when no transition arrives within the timeout.

Behaviour:
- Reset state: all outputs 0, state IDLE, counter 0, synchronizer flops 0.
- Async RESET clears everything immediately, including mid-count; released state is IDLE.
- Input path: 2-flop synchronizer, then a third flop for edge detect; both rising and falling edges count.
- Edge-to-output latency is fixed at 3 CLOCK_50 edges after the first sampling edge. Intervals are edge differences, so the latency cancels.
- States:
  - IDLE: counter held at 0; an edge moves to ARMED and clears the counter; no meas_valid.
  - ARMED/LOCKED: counter increments each cycle and saturates at all-ones.
  - On an edge, a new measurement is taken: half_period = cycles between the two edge detections (edges at t0 and t1 give t1-t0). The counter restarts and meas_valid pulses.
- Classification: nominal[i] = CLK_HZ/8 * {1,2,4,6,8,12,16,24,32}. rate_code = i+1 if |m - nominal[i]| <= nominal[i] >> TOL_SHIFT, else 0. The tolerance windows do not overlap.
- Lock rule: LOCKED when the new code is nonzero and equals the previous code. Any other measurement returns to ARMED with locked=0.
- Timeout: in ARMED/LOCKED, when the counter reaches TIMEOUT_EIGHTHS*CLK_HZ/8 with no edge in that cycle:
  - timeout pulses for one cycle;
  - state goes to IDLE;
  - rate_code, half_period and locked clear to 0;
  - the previous code clears.
- Simultaneous edge and timeout threshold: the edge wins; no timeout pulse.
- Outputs are registered and hold between meas_valid pulses.
- All arithmetic is unsigned, CNT_W wide. Tolerance shifts are computed at elaboration.

Decomposition:
- Package blink_rate_pkg holds:
  - NUM_RATES = 9;
  - the eighths table {1,2,4,6,8,12,16,24,32};
  - RATE_UNKNOWN = 0;
  - the state enum IDLE/ARMED/LOCKED.
- One sub-module, sync_edge: 2-flop synchronizer plus edge detect with an async active-high reset; outputs a one-cycle edge pulse.

Test Plan:
All scenarios use CLK_HZ=8000, so 1 s = 8000 clocks and the timeout is 40000 clocks.
- Reset, then toggle blink_in every 8000 clocks, 4 times -> first toggle gives no meas_valid. Following measurements show half_period=8000, rate_code=5. locked=1 from the second measurement on.
- Toggle every 1000, then 1060, then 1100 clocks -> codes 1, 1, then 0. locked drops to 0 on the 1100 measurement.
- Stop toggling after lock at 8000 -> timeout pulses exactly 40000 clocks after the last edge detection. rate_code=0, half_period=0, locked=0. The next toggle produces no meas_valid.
- Switch the rate from 8000 to 16000 clocks mid-stream -> first 16000 measurement gives code 7 with locked=0. The second gives code 7 with locked=1.
- Assert RESET between clock edges mid-interval while locked -> all outputs 0 without waiting for a clock edge. After release, the first toggle only arms.
- Glitch: two edges one clock apart while locked at code 5 -> half_period=1, rate_code=0, locked=0.
